// File: rtl/wlmont_pkg.sv
// wlmont_pkg: shared helpers for the word-level Montgomery reduction pipe.
//   wl_iters    - minimum word iterations needed to cover LOGQ bits
//   wl_latency  - acceptance-to-out_valid latency in cycles
//   wl_next_pw  - partial-result width after one word iteration
//   wl_pw       - partial-result width entering iteration i
// Build option: WLMONT_LAZY_EN removes the final conditional subtraction
// (result in [0, 2q), one cycle less latency).
package wlmont_pkg;

    function automatic int wl_iters(input int logq, input int w);
        return (logq + w - 1) / w;
    endfunction

    function automatic int wl_latency(input int l, input int mullat, input bit lazy);
        return l * mullat + (lazy ? 0 : 1);
    endfunction

    // The sum A + m*q needs max(IW, W+LOGQ)+1 bits; dropping the W zero
    // low bits gives the next partial width.
    function automatic int wl_next_pw(input int iw, input int logq, input int w);
        return ((iw > w + logq) ? iw : w + logq) + 1 - w;
    endfunction

    function automatic int wl_pw(input int logq, input int w, input int i);
        int pw;
        pw = 2 * logq;
        for (int k = 0; k < i; k++) begin
            pw = wl_next_pw(pw, logq, w);
        end
        return pw;
    endfunction

endpackage

// File: rtl/wlmont_word_stage.sv
// wlmont_word_stage: one Montgomery word iteration
//   m = (-A) mod 2^W ; A' = (A + m*q) >> W
// followed by MULLAT register stages that all advance on en.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                global advance; registers hold when low
//   in_valid/tag/q/a  incoming stage record (partial width IW)
//   out_valid/tag/q/a outgoing stage record (partial width OW)
module wlmont_word_stage
    import wlmont_pkg::*;
#(
    parameter  int LOGQ   = 60,
    parameter  int W      = 15,
    parameter  int MULLAT = 1,
    parameter  int TAGW   = 8,
    parameter  int IW     = 120,
    localparam int OW     = wl_next_pw(IW, LOGQ, W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            in_valid,
    input  logic [TAGW-1:0] in_tag,
    input  logic [LOGQ-1:0] in_q,
    input  logic [IW-1:0]   in_a,
    output logic            out_valid,
    output logic [TAGW-1:0] out_tag,
    output logic [LOGQ-1:0] out_q,
    output logic [OW-1:0]   out_a
);

    localparam int SW = ((IW > W + LOGQ) ? IW : W + LOGQ) + 1;

    typedef struct packed {
        logic            valid;
        logic [TAGW-1:0] tag;
        logic [LOGQ-1:0] q;
        logic [OW-1:0]   partial;
    } stage_t;

    logic [W-1:0] m;
    stage_t       nxt;
    stage_t       pipe [MULLAT];

    // Low W bits of the sum are zero by construction, so only the shifted
    // value is kept. Extra registers after the multiply are left for retiming.
    always_comb begin
        m           = W'(0) - in_a[W-1:0];
        nxt.valid   = in_valid;
        nxt.tag     = in_tag;
        nxt.q       = in_q;
        nxt.partial = OW'((SW'(in_a) + SW'(m) * SW'(in_q)) >> W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MULLAT; k++) begin
                pipe[k] <= '0;
            end
        end else if (en) begin
            pipe[0] <= nxt;
            for (int k = 1; k < MULLAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign out_valid = pipe[MULLAT-1].valid;
    assign out_tag   = pipe[MULLAT-1].tag;
    assign out_q     = pipe[MULLAT-1].q;
    assign out_a     = pipe[MULLAT-1].partial;

endmodule

// File: rtl/wlmont_pipe.sv
// wlmont_pipe: multi-modulus, stallable word-level Montgomery reduction.
// Returns A * 2^(-L*W) mod q, with q taken from a runtime-writable table.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_q    modulus table write
//   in_valid/in_ready        input handshake; in_a operand (< q^2),
//   in_qsel, in_tag          table index and opaque sideband
//   out_valid/out_ready      output handshake; out_b result, out_tag sideband
// Build option: WLMONT_LAZY_EN drops the final subtraction; out_b in [0, 2q).
module wlmont_pipe
    import wlmont_pkg::*;
#(
    parameter  int LOGQ   = 60,
    parameter  int W      = 15,
    parameter  int L      = 4,
    parameter  int MULLAT = 1,
    parameter  int NQ     = 4,
    parameter  int TAGW   = 8,
    localparam int QSW    = (NQ > 1) ? $clog2(NQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [QSW-1:0]    cfg_addr,
    input  logic [LOGQ-1:0]   cfg_q,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*LOGQ-1:0] in_a,
    input  logic [QSW-1:0]    in_qsel,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOGQ:0]     out_b,
    output logic [TAGW-1:0]   out_tag
);

    logic [LOGQ-1:0] q_tab [NQ];
    logic            advance;

    // Global stall: every stage moves only when the output slot frees up.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Reads below see the pre-write value, so a same-cycle write and
    // acceptance to one index hands the old modulus to the operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NQ; k++) begin
                q_tab[k] <= '0;
            end
        end else if (cfg_we) begin
            q_tab[cfg_addr] <= cfg_q;
        end
    end

    for (genvar i = 0; i < L; i++) begin : g_st
        localparam int IW = wl_pw(LOGQ, W, i);
        localparam int OW = wl_pw(LOGQ, W, i + 1);

        logic            v_i;
        logic [TAGW-1:0] t_i;
        logic [LOGQ-1:0] q_i;
        logic [IW-1:0]   a_i;
        logic            v_o;
        logic [TAGW-1:0] t_o;
        logic [LOGQ-1:0] q_o;
        logic [OW-1:0]   a_o;

        if (i == 0) begin : g_head
            assign v_i = in_valid;
            assign t_i = in_tag;
            assign q_i = q_tab[in_qsel];
            assign a_i = in_a;
        end else begin : g_link
            assign v_i = g_st[i-1].v_o;
            assign t_i = g_st[i-1].t_o;
            assign q_i = g_st[i-1].q_o;
            assign a_i = g_st[i-1].a_o;
        end

        wlmont_word_stage #(
            .LOGQ   (LOGQ),
            .W      (W),
            .MULLAT (MULLAT),
            .TAGW   (TAGW),
            .IW     (IW)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (advance),
            .in_valid  (v_i),
            .in_tag    (t_i),
            .in_q      (q_i),
            .in_a      (a_i),
            .out_valid (v_o),
            .out_tag   (t_o),
            .out_q     (q_o),
            .out_a     (a_o)
        );
    end

    // A_L < 2q for in-range operands, so LOGQ+1 bits hold it.
    logic [LOGQ:0] b_raw;
    assign b_raw = (LOGQ+1)'(g_st[L-1].a_o);

`ifdef WLMONT_LAZY_EN
    assign out_valid = g_st[L-1].v_o;
    assign out_tag   = g_st[L-1].t_o;
    assign out_b     = b_raw;
`else
    logic [LOGQ:0] b_fix;

    always_comb begin
        b_fix = b_raw;
        if (b_raw >= {1'b0, g_st[L-1].q_o}) begin
            b_fix = b_raw - {1'b0, g_st[L-1].q_o};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_b     <= '0;
            out_tag   <= '0;
        end else if (advance) begin
            out_valid <= g_st[L-1].v_o;
            out_b     <= b_fix;
            out_tag   <= g_st[L-1].t_o;
        end
    end
`endif

endmodule

// File: tb/tb_wlmont_pipe.sv
module tb_wlmont_pipe;

    localparam int LOGQ   = 17;
    localparam int W      = 8;
    localparam int L      = 3;
    localparam int MULLAT = 1;
    localparam int NQ     = 4;
    localparam int TAGW   = 8;
`ifdef WLMONT_LAZY_EN
    localparam int LAT    = L * MULLAT;
`else
    localparam int LAT    = L * MULLAT + 1;
`endif

    logic              clk;
    logic              rst;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [LOGQ-1:0]   cfg_q;
    logic              in_valid;
    logic              in_ready;
    logic [2*LOGQ-1:0] in_a;
    logic [1:0]        in_qsel;
    logic [TAGW-1:0]   in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [LOGQ:0]     out_b;
    logic [TAGW-1:0]   out_tag;

    wlmont_pipe #(
        .LOGQ(LOGQ), .W(W), .L(L), .MULLAT(MULLAT), .NQ(NQ), .TAGW(TAGW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_q(cfg_q),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_qsel(in_qsel), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_b(out_b), .out_tag(out_tag)
    );

    typedef struct {
        logic [63:0]     a;
        longint          q;
        logic [TAGW-1:0] tag;
        int              acc;
        bit              lat;
    } sb_t;

    sb_t    sb [$];
    longint tbl_m [NQ];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    int     out_cnt = 0;
    bit     mon_en  = 0;
    bit     chk_lat = 0;
    bit     rnd_rdy = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a * R^-1 mod q with R = 2^(L*W), built from the inverse of 2.
    function automatic longint mont_ref(input logic [63:0] a, input longint q);
        longint inv2, rinv, am;
        inv2 = (q + 1) / 2;
        rinv = 1;
        for (int i = 0; i < L * W; i++) rinv = (rinv * inv2) % q;
        am = longint'(a % 64'(q));
        return (am * rinv) % q;
    endfunction

    // Monitor / scoreboard, sampled mid-cycle.
    initial forever begin
        sb_t it;
        longint e;
        @(negedge clk);
        if (mon_en) begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
            if (out_valid && out_ready) begin
                out_cnt++;
                if (sb.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    it = sb.pop_front();
                    e  = mont_ref(it.a, it.q);
                    chk("tag", 64'(out_tag), 64'(it.tag));
`ifdef WLMONT_LAZY_EN
                    chk("b_mod_q", 64'(longint'(out_b) % it.q), 64'(e));
                    chk("b_lt_2q", {63'd0, (longint'(out_b) < 2 * it.q)}, 64'd1);
`else
                    chk("b", 64'(out_b), 64'(e));
`endif
                    if (it.lat) chk("latency", 64'(cyc - it.acc), 64'(LAT));
                end
            end
            if (in_valid && in_ready) begin
                it.a   = 64'(in_a);
                it.q   = tbl_m[in_qsel];
                it.tag = in_tag;
                it.acc = cyc;
                it.lat = chk_lat;
                sb.push_back(it);
            end
            if (cfg_we) tbl_m[cfg_addr] = longint'(cfg_q);
            if (rst) begin
                sb.delete();
                foreach (tbl_m[k]) tbl_m[k] = 0;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input logic [63:0] a, input logic [1:0] qs, input logic [TAGW-1:0] tg);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_a     = a[2*LOGQ-1:0];
        in_qsel  = qs;
        in_tag   = tg;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [LOGQ-1:0] q);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_q    = q;
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int          c0;
        logic [63:0] r;
        longint      qq;

        rst      = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_q    = '0;
        in_valid = 1'b0;
        in_a     = '0;
        in_qsel  = '0;
        in_tag   = '0;
        foreach (tbl_m[k]) tbl_m[k] = 0;
        idle(3);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_b", 64'(out_b), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Basic vectors and the (q-1)^2 boundary, latency checked.
        cfg_write(2'd0, 17'd65537);
        chk_lat = 1'b1;
        send(64'd1, 2'd0, 8'd1);
        idle(6);
        send(64'd16777216, 2'd0, 8'd2);
        send(64'd0, 2'd0, 8'd3);
        send(64'd327685, 2'd0, 8'd4);
        send(64'd4294967296, 2'd0, 8'd5);
        send(64'd196608, 2'd0, 8'd6);
        wait_drain();

        // Interleaved moduli.
        cfg_write(2'd1, 17'd257);
        for (int i = 0; i < 6; i++) send(64'd1, 2'(i % 2), 8'(10 + i));
        wait_drain();
        chk_lat = 1'b0;

        // Table rewrite with operations in flight, including a same-cycle
        // write and acceptance.
        send(64'd1, 2'd1, 8'd20);
        send(64'd1, 2'd1, 8'd21);
        cfg_we   = 1'b1;
        cfg_addr = 2'd1;
        cfg_q    = 17'd769;
        send(64'd1, 2'd1, 8'd22);
        cfg_we   = 1'b0;
        send(64'd1, 2'd1, 8'd23);
        send(64'd3, 2'd1, 8'd24);
        wait_drain();

        // Streaming with random backpressure.
        c0      = out_cnt;
        qq      = 64'd65537 * 64'd65537;
        rnd_rdy = 1'b1;
        for (int i = 0; i < 32; i++) begin
            r = {32'($urandom), 32'($urandom)} % 64'(qq);
            send(r, 2'd0, 8'(i));
        end
        rnd_rdy = 1'b0;
        wait_drain();
        chk("stream_count", 64'(out_cnt - c0), 64'd32);

        // Reset with operations in flight.
        idle(2);
        for (int i = 0; i < 5; i++) send(64'(1 + i), 2'd0, 8'(40 + i));
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_b", 64'(out_b), 64'd0);
        c0 = out_cnt;
        idle(12);
        chk("rst_stale", 64'(out_cnt - c0), 64'd0);

        // Recovery after reset.
        cfg_write(2'd0, 17'd65537);
        send(64'd4294967296, 2'd0, 8'd50);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
